test_decrement_operations: RTL and testbench



---
 rtl/test_decrement_pkg.sv | 13 +
 rtl/test_decrement_operations_sat_counter.sv | 34 +++
 rtl/test_decrement_operations.sv | 111 +++++++++++
 tb/tb_test_decrement_operations.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/test_decrement_pkg.sv
// Shared types and defaults for the loadable down-counter.
package test_decrement_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH    = 8;
   localparam int unsigned DEF_RC_WIDTH = 8;

endpackage

// File: rtl/test_decrement_operations_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module test_decrement_operations_sat_counter #(
   parameter int unsigned RC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                inc,
   output logic [RC_WIDTH-1:0] count
);

   logic [RC_WIDTH-1:0] count_q;
   logic [RC_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != '1)) begin
         count_d = count_q + RC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/test_decrement_operations.sv
// Loadable down-counter / interval timer with optional auto-reload and a
// saturating count of completed reloads.
module test_decrement_operations
   import test_decrement_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned RC_WIDTH = DEF_RC_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [WIDTH-1:0]    load_value,
   input  logic                enable,
   input  logic                reload_en,
   input  logic                abort,
   output logic [WIDTH-1:0]    counter,
   output logic                busy,
   output logic                tc_pulse,
   output logic [RC_WIDTH-1:0] reload_count
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             busy_q, busy_d;
   logic             tc_q, tc_d;
   logic             rc_clr, rc_inc;

   assign load_ready = (state_q != ST_RUN) && !abort;

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      reload_d  = reload_q;
      tc_d      = 1'b0;
      rc_clr    = 1'b0;
      rc_inc    = 1'b0;

      unique case (state_q)
         ST_RUN: begin
            if (abort) begin
               state_d   = ST_IDLE;
               counter_d = '0;
            end else if (enable) begin
               if (counter_q > WIDTH'(1)) begin
                  counter_d = counter_q - WIDTH'(1);
               end else begin
                  // Expiry: reload_en only matters on this cycle.
                  tc_d = 1'b1;
                  if (reload_en) begin
                     counter_d = reload_q;
                     rc_inc    = 1'b1;
                  end else begin
                     counter_d = '0;
                     state_d   = ST_DONE;
                  end
               end
            end
         end
         default: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (load_valid) begin
               reload_d  = load_value;
               counter_d = load_value;
               rc_clr    = 1'b1;
               if (load_value != '0) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_DONE;
                  tc_d    = 1'b1;
               end
            end
         end
      endcase

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
         reload_q  <= '0;
         busy_q    <= 1'b0;
         tc_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         reload_q  <= reload_d;
         busy_q    <= busy_d;
         tc_q      <= tc_d;
      end
   end

   test_decrement_operations_sat_counter #(
      .RC_WIDTH (RC_WIDTH)
   ) u_reload_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (rc_clr),
      .inc   (rc_inc),
      .count (reload_count)
   );

   assign counter  = counter_q;
   assign busy     = busy_q;
   assign tc_pulse = tc_q;

endmodule

// File: tb/tb_test_decrement_operations.sv
// Directed bench for the down-counter: expected outputs are queued as each
// step is driven and compared once the following clock edge has settled.
module tb_test_decrement_operations;

   logic       clk;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_value;
   logic       enable;
   logic       reload_en;
   logic       abort;
   logic [7:0] counter;
   logic       busy;
   logic       tc_pulse;
   logic [7:0] reload_count;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      tag;
      logic [7:0] cnt;
      logic       busy;
      logic       tc;
      logic [7:0] rc;
      logic       ready;
   } exp_t;

   exp_t sb[$];

   test_decrement_operations #(
      .WIDTH    (8),
      .RC_WIDTH (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_value   (load_value),
      .enable       (enable),
      .reload_en    (reload_en),
      .abort        (abort),
      .counter      (counter),
      .busy         (busy),
      .tc_pulse     (tc_pulse),
      .reload_count (reload_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected post-edge outputs,
   // then pop and compare after the edge.
   task automatic step(input string tag, input logic lval, input logic [7:0] lv,
                       input logic ab, input logic [7:0] e_cnt, input logic e_busy,
                       input logic e_tc, input logic [7:0] e_rc, input logic e_ready);
      exp_t e;
      e.tag = tag; e.cnt = e_cnt; e.busy = e_busy; e.tc = e_tc; e.rc = e_rc; e.ready = e_ready;
      sb.push_back(e);
      load_valid = lval;
      load_value = lv;
      abort      = ab;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      abort      = 1'b0;
      #1;
      e = sb.pop_front();
      chk({e.tag, ".counter"}, 32'(counter),      32'(e.cnt));
      chk({e.tag, ".busy"},    32'(busy),         32'(e.busy));
      chk({e.tag, ".tc"},      32'(tc_pulse),     32'(e.tc));
      chk({e.tag, ".rc"},      32'(reload_count), 32'(e.rc));
      chk({e.tag, ".ready"},   32'(load_ready),   32'(e.ready));
   endtask

   initial begin
      logic [7:0] erc;
      rst = 1'b1; load_valid = 1'b0; load_value = '0;
      enable = 1'b0; reload_en = 1'b0; abort = 1'b0;

      // reset
      step("rst0", 0, 0, 0, 8'd0, 0, 0, 8'd0, 1);
      step("rst1", 0, 0, 0, 8'd0, 0, 0, 8'd0, 1);
      rst = 1'b0;

      // load 5, continuous enable, no reload
      enable = 1'b1; reload_en = 1'b0;
      step("l5.ld", 1, 8'd5, 0, 8'd5, 1, 0, 8'd0, 0);
      step("l5.4",  0, 0, 0, 8'd4, 1, 0, 8'd0, 0);
      step("l5.3",  0, 0, 0, 8'd3, 1, 0, 8'd0, 0);
      step("l5.2",  0, 0, 0, 8'd2, 1, 0, 8'd0, 0);
      step("l5.1",  0, 0, 0, 8'd1, 1, 0, 8'd0, 0);
      step("l5.0",  0, 0, 0, 8'd0, 0, 1, 8'd0, 1);
      step("l5.dn", 0, 0, 0, 8'd0, 0, 0, 8'd0, 1);

      // load 3, enable pattern 1,0,1,0,1
      step("l3.ld", 1, 8'd3, 0, 8'd3, 1, 0, 8'd0, 0);
      enable = 1'b1; step("l3.e1", 0, 0, 0, 8'd2, 1, 0, 8'd0, 0);
      enable = 1'b0; step("l3.e0", 0, 0, 0, 8'd2, 1, 0, 8'd0, 0);
      enable = 1'b1; step("l3.e1b", 0, 0, 0, 8'd1, 1, 0, 8'd0, 0);
      enable = 1'b0; step("l3.e0b", 0, 0, 0, 8'd1, 1, 0, 8'd0, 0);
      enable = 1'b1; step("l3.exp", 0, 0, 0, 8'd0, 0, 1, 8'd0, 1);

      // load 2 with auto-reload
      reload_en = 1'b1;
      step("r2.ld", 1, 8'd2, 0, 8'd2, 1, 0, 8'd0, 0);
      step("r2.a",  0, 0, 0, 8'd1, 1, 0, 8'd0, 0);
      step("r2.b",  0, 0, 0, 8'd2, 1, 1, 8'd1, 0);
      step("r2.c",  0, 0, 0, 8'd1, 1, 0, 8'd1, 0);
      step("r2.d",  0, 0, 0, 8'd2, 1, 1, 8'd2, 0);
      step("r2.e",  0, 0, 0, 8'd1, 1, 0, 8'd2, 0);
      step("r2.f",  0, 0, 0, 8'd2, 1, 1, 8'd3, 0);
      step("r2.ab", 0, 0, 1, 8'd0, 0, 0, 8'd3, 1);

      // zero load: straight to DONE with a single tc pulse
      reload_en = 1'b0;
      step("z.ld",  1, 8'd0, 0, 8'd0, 0, 1, 8'd0, 1);
      step("z.dn",  0, 0, 0, 8'd0, 0, 0, 8'd0, 1);

      // load 10, abort after four decrements
      step("a10.ld", 1, 8'd10, 0, 8'd10, 1, 0, 8'd0, 0);
      step("a10.9",  0, 0, 0, 8'd9, 1, 0, 8'd0, 0);
      step("a10.8",  0, 0, 0, 8'd8, 1, 0, 8'd0, 0);
      step("a10.7",  0, 0, 0, 8'd7, 1, 0, 8'd0, 0);
      step("a10.6",  0, 0, 0, 8'd6, 1, 0, 8'd0, 0);
      step("a10.ab", 0, 0, 1, 8'd0, 0, 0, 8'd0, 1);

      // abort + load_valid together in DONE: load refused
      step("d.ld0", 1, 8'd0, 0, 8'd0, 0, 1, 8'd0, 1);
      load_valid = 1'b1; load_value = 8'd7; abort = 1'b1;
      #1;
      chk("d.ready_abort", 32'(load_ready), 32'd0);
      step("d.abld", 1, 8'd7, 1, 8'd0, 0, 0, 8'd0, 1);
      step("d.idle", 0, 0, 0, 8'd0, 0, 0, 8'd0, 1);

      // reload of 200: first expiry reloads the full value
      reload_en = 1'b1;
      step("r200.ld", 1, 8'd200, 0, 8'd200, 1, 0, 8'd0, 0);
      for (int i = 1; i < 200; i++) begin
         step("r200.dec", 0, 0, 0, 8'(200 - i), 1, 0, 8'd0, 0);
      end
      step("r200.exp", 0, 0, 0, 8'd200, 1, 1, 8'd1, 0);
      step("r200.ab",  0, 0, 1, 8'd0, 0, 0, 8'd1, 1);

      // reload of 1: tc every cycle, reload_count saturates at 255
      step("r1.ld", 1, 8'd1, 0, 8'd1, 1, 0, 8'd0, 0);
      for (int i = 1; i <= 300; i++) begin
         erc = (i > 255) ? 8'd255 : 8'(i);
         step("r1.sat", 0, 0, 0, 8'd1, 1, 1, erc, 0);
      end

      // reset mid-run, even with a load offered
      rst = 1'b1;
      step("mrst", 1, 8'd9, 0, 8'd0, 0, 0, 8'd0, 1);
      rst = 1'b0;
      step("mrst.idle", 0, 0, 0, 8'd0, 0, 0, 8'd0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
